// File: rtl/prg_pixel_sched.sv
`default_nettype none
// ============================================================================
// Module   : prg_pixel_sched
// Purpose  : Primary-ray pixel/sample scheduler. Walks the frame in raster or
//            tiled order, issues (x,y,s) tokens to a fixed-latency datapath,
//            and buffers the returning rays in a credit-protected FIFO.
// Revision : 1.0  initial release
// ============================================================================
module prg_pixel_sched #(
    parameter int NUM_COLS   = 640,
    parameter int NUM_ROWS   = 480,
    parameter int SPP        = 1,
    parameter int TILE_W     = 8,
    parameter int TILE_H     = 8,
    parameter int PIPE_DEPTH = 40,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 211,
    localparam int XW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int YW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int SW = (SPP > 1) ? $clog2(SPP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              tile_mode_i,
    input  logic              v0_i,
    output logic              issue_valid_o,
    output logic [XW-1:0]     issue_x_o,
    output logic [YW-1:0]     issue_y_o,
    output logic [SW-1:0]     issue_s_o,
    input  logic              ret_valid_i,
    input  logic [DATA_W-1:0] ret_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_stall_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int HW = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(NUM_COLS - 1);
    localparam logic [XW-1:0] TX_LAST  = XW'(NUM_COLS - TILE_W);
    localparam logic [XW-1:0] TW_STEP  = XW'(TILE_W);
    localparam logic [XW-1:0] TW_M1    = XW'(TILE_W - 1);
    localparam logic [YW-1:0] Y_FIRST  = YW'(NUM_ROWS - 1);
    localparam logic [YW-1:0] TY_FIRST = YW'(NUM_ROWS - TILE_H);
    localparam logic [YW-1:0] TH_STEP  = YW'(TILE_H);
    localparam logic [YW-1:0] TH_M1    = YW'(TILE_H - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(SPP - 1);
    localparam logic [CW-1:0] C_FULL   = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] C_HOLD   = HW'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              tile_q, tile_d;
    logic [XW-1:0]     x_q, x_d, tx_q, tx_d;
    logic [YW-1:0]     y_q, y_d, ty_q, ty_d;
    logic [SW-1:0]     s_q, s_d;
    logic [CW-1:0]     infl_q, infl_d, cnt_q, cnt_d;
    logic [AW-1:0]     wp_q, rp_q;
    logic [HW-1:0]     hold_q;
    logic              err_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic w_hold, w_full, w_pop, w_ret, w_bad, w_wr, w_dec, w_credit, w_issue, w_last;

    assign w_hold   = (hold_q != '0);
    assign w_full   = (cnt_q == C_FULL);
    assign w_pop    = out_valid_o & ~out_stall_i;
    assign w_ret    = ret_valid_i & ~w_hold;
    // A return nobody asked for, or one with nowhere to go, is dropped and flagged.
    assign w_bad    = w_ret & ((w_full & ~w_pop) | (infl_q == '0));
    assign w_wr     = w_ret & ~w_bad;
    assign w_dec    = w_ret & (infl_q != '0);
    assign w_credit = ({1'b0, infl_q} + {1'b0, cnt_q}) < {1'b0, C_FULL};
    assign w_issue  = (state_q == S_RUN) & v0_i & w_credit;
    assign w_last   = (x_q == X_LAST) & (y_q == '0) & (s_q == S_LAST);

    assign infl_d = infl_q + CW'(w_issue) - CW'(w_dec);
    assign cnt_d  = cnt_q + CW'(w_wr) - CW'(w_pop);

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !w_hold) begin
                    state_d = S_RUN;
                    tile_d  = tile_mode_i;
                end
            end
            S_RUN: begin
                if (w_issue && w_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (infl_q == '0 && cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        s_d  = s_q;
        tx_d = tx_q;
        ty_d = ty_q;
        if (w_issue) begin
            if (w_last) begin
                x_d  = '0;
                y_d  = Y_FIRST;
                s_d  = '0;
                tx_d = '0;
                ty_d = TY_FIRST;
            end else if (s_q != S_LAST) begin
                s_d = s_q + SW'(1);
            end else begin
                s_d = '0;
                if (!tile_q) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q - YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else if (x_q != tx_q + TW_M1) begin
                    x_d = x_q + XW'(1);
                end else if (y_q != ty_q) begin
                    x_d = tx_q;
                    y_d = y_q - YW'(1);
                end else if (tx_q != TX_LAST) begin
                    // next tile to the right, back to its top row
                    tx_d = tx_q + TW_STEP;
                    x_d  = tx_q + TW_STEP;
                    y_d  = ty_q + TH_M1;
                end else begin
                    // first tile of the next tile row down
                    tx_d = '0;
                    x_d  = '0;
                    ty_d = ty_q - TH_STEP;
                    y_d  = ty_q - YW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tile_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= Y_FIRST;
            s_q     <= '0;
            tx_q    <= '0;
            ty_q    <= TY_FIRST;
            infl_q  <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            hold_q  <= C_HOLD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
            if (w_wr) begin
                wp_q <= wp_q + AW'(1);
            end
            if (w_pop) begin
                rp_q <= rp_q + AW'(1);
            end
            if (w_hold) begin
                hold_q <= hold_q - HW'(1);
            end
            err_q <= err_q | w_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wp_q] <= ret_data_i;
        end
    end

    assign issue_valid_o = w_issue;
    assign issue_x_o     = w_issue ? x_q : '0;
    assign issue_y_o     = w_issue ? y_q : '0;
    assign issue_s_o     = w_issue ? s_q : '0;
    assign out_valid_o   = (cnt_q != '0);
    assign out_data_o    = out_valid_o ? mem_q[rp_q] : '0;
    assign busy_o        = (state_q != S_IDLE);
    assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prg_pixel_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_prg_pixel_sched
// Purpose  : Self-checking bench for prg_pixel_sched with a 3-cycle delay line.
// Revision : 1.0  initial release
// ============================================================================
module tb_prg_pixel_sched;

    localparam int NC = 4;
    localparam int NR = 2;
    localparam int SP = 2;
    localparam int TW = 2;
    localparam int TH = 2;
    localparam int PD = 3;
    localparam int FD = 4;
    localparam int DW = 211;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          tile_mode = 1'b0;
    logic          v0 = 1'b0;
    logic          out_stall = 1'b0;
    logic          inj = 1'b0;
    logic [DW-1:0] inj_data = '0;
    logic          issue_valid, out_valid, busy, done, err, ret_valid;
    logic [1:0]    issue_x;
    logic [0:0]    issue_y, issue_s;
    logic [DW-1:0] ret_data, out_data;

    int checks = 0;
    int errors = 0;

    typedef struct {int x; int y; int s;} tok_t;
    tok_t          tok_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_iss, n_pop, n_done;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    prg_pixel_sched #(
        .NUM_COLS(NC), .NUM_ROWS(NR), .SPP(SP), .TILE_W(TW), .TILE_H(TH),
        .PIPE_DEPTH(PD), .FIFO_DEPTH(FD), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .tile_mode_i(tile_mode), .v0_i(v0),
        .issue_valid_o(issue_valid), .issue_x_o(issue_x), .issue_y_o(issue_y),
        .issue_s_o(issue_s), .ret_valid_i(ret_valid), .ret_data_i(ret_data),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_stall_i(out_stall),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    // External fixed-latency datapath: each issue returns a fresh random ray.
    bit            dl_v0, dl_v1, dl_v2;
    logic [DW-1:0] dl_d0, dl_d1, dl_d2;
    always @(posedge clk) begin
        logic [DW-1:0] nd;
        nd = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        if (issue_valid === 1'b1) exp_q.push_back(nd);
        dl_v0 <= (issue_valid === 1'b1);
        dl_d0 <= nd;
        dl_v1 <= dl_v0;
        dl_d1 <= dl_d0;
        dl_v2 <= dl_v1;
        dl_d2 <= dl_d1;
    end
    assign ret_valid = dl_v2 | inj;
    assign ret_data  = inj ? inj_data : dl_d2;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (issue_valid) begin
                check("tok_avail", 256'(tok_q.size() > 0), 256'(1));
                if (tok_q.size() > 0) begin
                    tok_t t;
                    t = tok_q.pop_front();
                    check("issue_x", 256'(issue_x), 256'(t.x));
                    check("issue_y", 256'(issue_y), 256'(t.y));
                    check("issue_s", 256'(issue_s), 256'(t.s));
                end
                check("issue_v0", 256'(v0), 256'(1));
                check("credit", 256'((n_iss - n_pop) < FD), 256'(1));
                n_iss++;
            end
            if (out_valid && !out_stall) begin
                check("pop_avail", 256'(exp_q.size() > 0), 256'(1));
                if (exp_q.size() > 0) check("out_data", 256'(out_data), 256'(exp_q.pop_front()));
                n_pop++;
            end
            if (done) n_done++;
        end
    end

    task automatic build(input bit tiled);
        tok_q.delete();
        if (!tiled) begin
            for (int y = NR - 1; y >= 0; y--)
                for (int x = 0; x < NC; x++)
                    for (int s = 0; s < SP; s++) tok_q.push_back('{x, y, s});
        end else begin
            for (int tr = NR / TH - 1; tr >= 0; tr--)
                for (int tc = 0; tc < NC / TW; tc++)
                    for (int y = tr * TH + TH - 1; y >= tr * TH; y--)
                        for (int x = tc * TW; x < tc * TW + TW; x++)
                            for (int s = 0; s < SP; s++) tok_q.push_back('{x, y, s});
        end
    endtask

    task automatic step(input int vmode, input int smode);
        @(posedge clk);
        #1;
        case (vmode)
            0:       v0 = 1'b1;
            1:       v0 = ~v0;
            default: v0 = 1'($urandom_range(0, 1));
        endcase
        case (smode)
            0:       out_stall = 1'b0;
            1:       out_stall = 1'b1;
            default: out_stall = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    task automatic run_frame(input bit tiled, input int vmode, input int smode,
                             input int stall_pre, input int kick, input bit exp_err);
        build(tiled);
        exp_q.delete();
        n_iss = 0; n_pop = 0; n_done = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1; tile_mode = tiled; v0 = 1'b1; out_stall = (stall_pre > 0);
        @(posedge clk);
        #1;
        start = 1'b0; tile_mode = ~tiled;
        check("busy_run", 256'(busy), 256'(1));
        for (int c = 0; c < stall_pre; c++) step(0, 1);
        if (stall_pre > 0) begin
            check("stall_issues", 256'(n_iss), 256'(FD));
            check("stall_noissue", 256'(issue_valid), 256'(0));
            check("stall_full", 256'(out_valid), 256'(1));
            check("stall_nopop", 256'(n_pop), 256'(0));
            check("stall_err", 256'(err), 256'(0));
        end
        for (int c = 0; c < 600 && n_done == 0; c++) begin
            step(vmode, smode);
            start = (c == kick);
        end
        start = 1'b0;
        repeat (5) step(0, 0);
        check("done_once", 256'(n_done), 256'(1));
        check("tok_left", 256'(tok_q.size()), 256'(0));
        check("data_left", 256'(exp_q.size()), 256'(0));
        check("n_issued", 256'(n_iss), 256'(NC * NR * SP));
        check("n_popped", 256'(n_pop), 256'(NC * NR * SP));
        check("idle_busy", 256'(busy), 256'(0));
        check("idle_empty", 256'(out_valid), 256'(0));
        check("frame_err", 256'(err), 256'(exp_err));
        mon_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_issue", 256'({issue_valid, issue_x, issue_y, issue_s}), 256'(0));
        check("rst_out", 256'({out_valid, out_data}), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        rst = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        check("holdoff_start", 256'(busy), 256'(0));
        repeat (3) @(posedge clk);

        run_frame(1'b0, 0, 0, 0, -1, 1'b0);   // raster, free running
        run_frame(1'b1, 0, 0, 0, -1, 1'b0);   // tiled
        run_frame(1'b0, 0, 0, 20, -1, 1'b0);  // stalled downstream, then released
        run_frame(1'b0, 1, 0, 0, -1, 1'b0);   // v0 toggling
        run_frame(1'($urandom_range(0, 1)), 2, 2, 0, -1, 1'b0);
        run_frame(1'($urandom_range(0, 1)), 2, 2, 0, -1, 1'b0);

        // Reset in the middle of a frame with three tokens outstanding.
        build(1'b0);
        exp_q.delete();
        n_iss = 0; n_pop = 0; n_done = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1; tile_mode = 1'b0; v0 = 1'b1; out_stall = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_issued", 256'(n_iss), 256'(3));
        rst = 1'b1; v0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_out", 256'(out_valid), 256'(0));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("late_drop", 256'({out_valid, err, busy}), 256'(0));
        end
        mon_en = 1'b0;
        exp_q.delete();

        // Unsolicited return sets the sticky error; restart attempt mid-frame is ignored.
        inj_data = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        check("inj_err", 256'(err), 256'(1));
        check("inj_drop", 256'(out_valid), 256'(0));
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 256'(err), 256'(1));
        run_frame(1'b0, 0, 0, 0, 4, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("err_clear", 256'(err), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
